// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-domain pointer and status controller for an asynchronous FIFO.
// Owns the binary/Gray read pointer, decodes the synchronized Gray write
// pointer and produces the RAM read address, empty / almost-empty flags,
// the occupancy count and a sticky underflow flag.
//
// Parameters
//   ADDRSIZE    RAM address width; FIFO depth is 2**ADDRSIZE.
//   AEMPTY_LVL  raempty asserts when occupancy <= AEMPTY_LVL.
//
// Ports
//   clk       in   read-domain clock
//   rst       in   asynchronous reset, active-low
//   rd_en     in   read request from user logic
//   rq2_wptr  in   Gray write pointer, already synchronized into clk
//   rptr      out  registered Gray read pointer, to write-domain synchronizer
//   raddr     out  registered RAM read address
//   rempty    out  registered empty flag
//   raempty   out  registered almost-empty flag
//   rcount    out  registered occupancy, 0..2**ADDRSIZE
//   rd_fire   out  combinational accepted-read strobe (rd_en & ~rempty)
//   rerr      out  sticky underflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDRSIZE   = 4,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                rd_fire,
    output logic                rerr
);

    localparam logic [ADDRSIZE:0] AEMPTY_THR = (ADDRSIZE+1)'(AEMPTY_LVL);

    logic [ADDRSIZE:0]   rbin_q,    rbin_d;
    logic [ADDRSIZE:0]   rptr_q,    rptr_d;
    logic [ADDRSIZE-1:0] raddr_q,   raddr_d;
    logic [ADDRSIZE:0]   rcount_q,  rcount_d;
    logic                rempty_q,  rempty_d;
    logic                raempty_q, raempty_d;
    logic                rerr_q,    rerr_d;

    logic [ADDRSIZE:0]   wbin;

    // A read is only accepted against the registered empty flag, so the
    // strobe never grants a word the RAM does not yet hold.
    assign rd_fire = rd_en & ~rempty_q;

    // Gray-to-binary decode of the synchronized write pointer: each binary
    // bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a value before any branch so
        // no path can leave it unassigned and infer a latch.
        rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, rd_fire};
        rptr_d    = rbin_d ^ (rbin_d >> 1);
        raddr_d   = rbin_d[ADDRSIZE-1:0];
        // Uses this cycle's write pointer and this cycle's read together, so
        // a simultaneous write and read leaves the count unchanged.
        rcount_d  = wbin - rbin_d;
        // Gray compare is equivalent to rcount_d == 0 but avoids the
        // subtractor on the empty path.
        rempty_d  = (rptr_d == rq2_wptr);
        raempty_d = (rcount_d <= AEMPTY_THR);
        rerr_d    = rerr_q | (rd_en & rempty_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            raddr_q   <= '0;
            rcount_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rerr_q    <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            raddr_q   <= raddr_d;
            rcount_q  <= rcount_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rerr_q    <= rerr_d;
        end
    end

    assign rptr    = rptr_q;
    assign raddr   = raddr_q;
    assign rcount  = rcount_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rerr    = rerr_q;

endmodule
